dot_seq_ctrl: RTL
=================

Name: dot_seq_ctrl

Overview:
Sequencer for the main_dotv2 dot-product datapath. On a start pulse it streams BEATS consecutive DATA_N-wide chunks of input and weight vectors from two synchronous-read buffers into main_dotv2, holds run for exactly those beats, then waits for valid and latches the HID_LENGTH-wide result. It sits between the layer-level control and main_dotv2, and raises a timeout error if the datapath never answers.

Parameters:
BIT_LENGTH, 16, width of one element
DATA_N, 6, elements per beat
HID_LENGTH, 24, elements in dot result
BEATS, 8, chunks streamed per operation
ADDR_W, 8, buffer address width
TIMEOUT, 64, max WAIT cycles before error

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin operation (sampled only in IDLE)
in_base  in  ADDR_W  input buffer start address, sampled with start
w_base  in  ADDR_W  weight buffer start address, sampled with start
in_addr  out  ADDR_W  input buffer read address
w_addr  out  ADDR_W  weight buffer read address
rd_en  out  1  buffer read enable
in_rdata  in  DATA_N*BIT_LENGTH  input buffer data, 1-cycle read latency
w_rdata  in  DATA_N*BIT_LENGTH  weight buffer data, 1-cycle read latency
dot_run  out  1  run to main_dotv2
dot_data_in  out  DATA_N*BIT_LENGTH  data_in to main_dotv2
dot_weight_in  out  DATA_N*BIT_LENGTH  weight_in to main_dotv2
dot_valid  in  1  valid from main_dotv2
dot_data_out  in  HID_LENGTH*BIT_LENGTH  data_out from main_dotv2
result  out  HID_LENGTH*BIT_LENGTH  latched dot result
result_valid  out  1  result holds a fresh value
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
error  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset is asynchronous; asserting it mid-operation aborts immediately and a later start begins from scratch.
- States: IDLE, STREAM, DRAIN, WAIT, DONE.
- IDLE: when start=1, latch in_base and w_base, clear error and result_valid, then go to STREAM. start is ignored in every other state, including DONE.
- STREAM: lasts BEATS cycles with beat counter k=0..BEATS-1. rd_en=1, in_addr=in_base+k, w_addr=w_base+k. Addition is mod 2^ADDR_W, so addresses wrap. After k=BEATS-1, go to DRAIN.
- Data path: rd_en is delayed one cycle to produce dot_run. dot_data_in and dot_weight_in are registered copies of in_rdata and w_rdata, updated only when the delayed rd_en is high, and zero otherwise.
- dot_run is therefore high for exactly BEATS consecutive cycles, starting 2 cycles after start is sampled (counting start-sample cycle = 0). Data changes on the same edge as run.
- DRAIN: one cycle, while the last beat is presented; then go to WAIT.
- WAIT: timeout counter increments every cycle.
  - dot_valid=1: result <= dot_data_out, result_valid=1, go to DONE.
  - Counter reaches TIMEOUT-1 without valid: error=1, result and result_valid unchanged (0), go to DONE.
  - dot_valid and timeout in the same cycle: valid wins, error stays 0.
- dot_valid outside WAIT is ignored.
- DONE: done=1 for one cycle, then IDLE. result holds until the next accepted start.
- busy=1 in STREAM, DRAIN, WAIT and DONE.

Test Plan:
- Basic run. BEATS=8, in_base=0, w_base=16; buffers hold vectors such as data {-3,-5,-1,-5,-8,-9} and weight {2,5,9,2,3,5} …; stub dot_valid 3 cycles after run falls. Expect: in_addr 0..7 and w_addr 16..23 on cycles 1..8; dot_run high on cycles 2..9 with matching data; result equals the stub's data_out; result_valid=1; one done pulse; error=0.
- Start while busy. Pulse start again at cycle 4. Expect: no address restart, exactly one done pulse, latched bases unchanged.
- Timeout. Hold dot_valid=0. Expect: error=1 after 64 WAIT cycles, done pulses once, result_valid=0. The next start clears error.
- Simultaneous valid and timeout. Assert dot_valid on the final WAIT cycle. Expect: result latched, error=0.
- Address wrap. in_base=254, BEATS=8. Expect: in_addr sequence 254, 255, 0, 1, …, 5.
- Reset mid-STREAM. Drop rst_n at cycle 5. Expect: all outputs 0 asynchronously. After release and a new start, the full 8-beat sequence restarts from base.

Source files
------------

// File: rtl/dot_seq_ctrl.sv
// Sequencer that streams BEATS chunks of input/weight vectors from two buffers into
// main_dotv2, then waits for its valid (with a timeout) and latches the dot result.
module dot_seq_ctrl #(
    parameter int BIT_LENGTH = 16,
    parameter int DATA_N     = 6,
    parameter int HID_LENGTH = 24,
    parameter int BEATS      = 8,
    parameter int ADDR_W     = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                in_base,
    input  logic [ADDR_W-1:0]                w_base,
    output logic [ADDR_W-1:0]                in_addr,
    output logic [ADDR_W-1:0]                w_addr,
    output logic                             rd_en,
    input  logic [DATA_N*BIT_LENGTH-1:0]     in_rdata,
    input  logic [DATA_N*BIT_LENGTH-1:0]     w_rdata,
    output logic                             dot_run,
    output logic [DATA_N*BIT_LENGTH-1:0]     dot_data_in,
    output logic [DATA_N*BIT_LENGTH-1:0]     dot_weight_in,
    input  logic                             dot_valid,
    input  logic [HID_LENGTH*BIT_LENGTH-1:0] dot_data_out,
    output logic [HID_LENGTH*BIT_LENGTH-1:0] result,
    output logic                             result_valid,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    localparam int DW = DATA_N * BIT_LENGTH;
    localparam int RW = HID_LENGTH * BIT_LENGTH;
    localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [KW-1:0] LAST_BEAT = KW'(BEATS - 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_DRAIN  = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [KW-1:0]     beat_q, beat_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [ADDR_W-1:0] in_base_q, in_base_d;
    logic [ADDR_W-1:0] w_base_q, w_base_d;
    logic              run_q, run_d;
    logic [RW-1:0]     result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              error_q, error_d;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            beat_q         <= '0;
            tmo_q          <= '0;
            in_base_q      <= '0;
            w_base_q       <= '0;
            run_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            tmo_q          <= tmo_d;
            in_base_q      <= in_base_d;
            w_base_q       <= w_base_d;
            run_q          <= run_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        tmo_d          = tmo_q;
        in_base_d      = in_base_q;
        w_base_d       = w_base_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        error_d        = error_q;
        run_d          = (state_q == S_STREAM);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_STREAM;
                    in_base_d      = in_base;
                    w_base_d       = w_base;
                    beat_d         = '0;
                    result_d       = '0;
                    result_valid_d = 1'b0;
                    error_d        = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = S_DRAIN;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + KW'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_WAIT;
                tmo_d   = '0;
            end
            S_WAIT: begin
                // A valid arriving on the last allowed cycle still wins over the timeout.
                if (dot_valid) begin
                    result_d       = dot_data_out;
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end else if (tmo_q == LAST_WAIT) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; buffer read data is already registered in the RAM.
    always_comb begin
        rd_en         = (state_q == S_STREAM);
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        dot_run       = run_q;
        result        = result_q;
        result_valid  = result_valid_q;
        error         = error_q;
        if (state_q == S_STREAM) begin
            in_addr = in_base_q + ADDR_W'(beat_q);
            w_addr  = w_base_q + ADDR_W'(beat_q);
        end else begin
            in_addr = '0;
            w_addr  = '0;
        end
        if (run_q) begin
            dot_data_in   = in_rdata;
            dot_weight_in = w_rdata;
        end else begin
            dot_data_in   = {DW{1'b0}};
            dot_weight_in = {DW{1'b0}};
        end
    end

endmodule
